// File: rtl/compare4a.sv
// Registered magnitude comparator: one-hot relation code plus sorted operand pair,
// unsigned or two's-complement per transaction, one-cycle latency.
module compare4a #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       y,
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o,
    output logic             out_valid
);

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             a_gt;
    logic             a_eq;
    logic [2:0]       y_d;
    logic [WIDTH-1:0] max_d;
    logic [WIDTH-1:0] min_d;

    logic [2:0]       y_q;
    logic [WIDTH-1:0] max_q;
    logic [WIDTH-1:0] min_q;
    logic             valid_q;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_key = a;
        b_key = b;
        if (signed_mode) begin
            a_key[WIDTH-1] = ~a[WIDTH-1];
            b_key[WIDTH-1] = ~b[WIDTH-1];
        end
    end

    assign a_eq = (a == b);
    assign a_gt = (a_key > b_key);

    always_comb begin
        y_d   = {a_gt, a_eq, ~a_gt & ~a_eq};
        max_d = a;
        min_d = b;
        if (!a_gt && !a_eq) begin
            max_d = b;
            min_d = a;
        end
    end

    // Result registers hold their value between transactions; only valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= 3'b000;
            max_q   <= '0;
            min_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                y_q   <= y_d;
                max_q <= max_d;
                min_q <= min_d;
            end
        end
    end

    assign y         = y_q;
    assign max_o     = max_q;
    assign min_o     = min_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_compare4a.sv
// Directed-vector bench for compare4a (WIDTH=4): async reset, unsigned and signed
// ordering, hold behaviour and reset in the middle of a valid stream.
module tb_compare4a;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       signed_mode = 1'b0;
    logic [3:0] a = 4'h0;
    logic [3:0] b = 4'h0;
    logic [2:0] y;
    logic [3:0] max_o;
    logic [3:0] min_o;
    logic       out_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    compare4a #(.WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .signed_mode(signed_mode),
        .a(a),
        .b(b),
        .y(y),
        .max_o(max_o),
        .min_o(min_o),
        .out_valid(out_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] ey, input logic [3:0] emax,
                             input logic [3:0] emin, input logic ev);
        check({tag, ".y"},   {29'd0, y},     {29'd0, ey});
        check({tag, ".max"}, {28'd0, max_o}, {28'd0, emax});
        check({tag, ".min"}, {28'd0, min_o}, {28'd0, emin});
        check({tag, ".vld"}, {31'd0, out_valid}, {31'd0, ev});
        $display("step %-10s a=%h b=%h s=%0b -> y=%b max=%h min=%h vld=%0b",
                 tag, a, b, signed_mode, y, max_o, min_o, out_valid);
    endtask

    // Drive one valid vector at the falling edge, check one cycle later.
    task automatic vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                       input logic sm, input logic [2:0] ey, input logic [3:0] emax,
                       input logic [3:0] emin);
        @(negedge clk);
        a = va; b = vb; signed_mode = sm; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag, ey, emax, emin, 1'b1);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1 check_all("rst_async", 3'b000, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1 check_all("rst_hold", 3'b000, 4'h0, 4'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("u_2_C",  4'h2, 4'hC, 1'b0, 3'b001, 4'hC, 4'h2);
        vec("u_1_1",  4'h1, 4'h1, 1'b0, 3'b010, 4'h1, 4'h1);
        vec("u_1_8",  4'h1, 4'h8, 1'b0, 3'b001, 4'h8, 4'h1);
        vec("s_1_8",  4'h1, 4'h8, 1'b1, 3'b100, 4'h1, 4'h8);
        vec("s_8_7",  4'h8, 4'h7, 1'b1, 3'b001, 4'h7, 4'h8);
        vec("u_8_7",  4'h8, 4'h7, 1'b0, 3'b100, 4'h8, 4'h7);
        vec("s_F_1",  4'hF, 4'h1, 1'b1, 3'b001, 4'h1, 4'hF);
        vec("u_F_1",  4'hF, 4'h1, 1'b0, 3'b100, 4'hF, 4'h1);
        vec("s_8_8",  4'h8, 4'h8, 1'b1, 3'b010, 4'h8, 4'h8);
        vec("u_0_F",  4'h0, 4'hF, 1'b0, 3'b001, 4'hF, 4'h0);
        vec("s_7_F",  4'h7, 4'hF, 1'b1, 3'b100, 4'h7, 4'hF);

        // Idle cycles: valid drops, results hold even though inputs change
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; a = 4'h3; b = 4'h9; signed_mode = 1'b0;
            @(posedge clk);
            #1 check_all("hold", 3'b100, 4'h7, 4'hF, 1'b0);
        end

        // Back-to-back stream interrupted by a mid-cycle reset
        vec("strm_0",  4'h4, 4'h2, 1'b0, 3'b100, 4'h4, 4'h2);
        @(negedge clk);
        a = 4'h1; b = 4'h6; signed_mode = 1'b0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_all("rst_mid", 3'b000, 4'h0, 4'h0, 1'b0);
        @(posedge clk);
        #1 check_all("rst_edge", 3'b000, 4'h0, 4'h0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        a = 4'h3; b = 4'h5; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 check_all("post_rst", 3'b001, 4'h5, 4'h3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1 check_all("post_idle", 3'b001, 4'h5, 4'h3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/compare4a.md
Name: compare4a

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 4 bits).
- Produces a one-hot relation code y (greater / equal / less), plus the larger and smaller operand.
- Supports unsigned and two's-complement comparison, selected per transaction.
- Used as a leaf datapath block wherever a sorted pair or a relation flag is needed; results are registered with a valid qualifier.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  a, b and signed_mode are sampled on this cycle.
- signed_mode  input  1  0 = unsigned comparison, 1 = two's-complement comparison.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- y  output  3  one-hot relation: y[2] = A>B, y[1] = A==B, y[0] = A<B.
- max_o  output  WIDTH  larger operand under the selected mode; equals a when A==B.
- min_o  output  WIDTH  smaller operand under the selected mode; equals b when A==B.
- out_valid  output  1  y, max_o and min_o hold a new result this cycle.

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears y to 3'b000, max_o and min_o to 0, and out_valid to 0, independent of clk.
  - Deassertion is sampled by clk.
  - y = 000 is the only legal non-one-hot value and means "no result yet".
- Latency is 1 cycle. If in_valid=1 at rising edge N, the result is visible after edge N and out_valid=1 for exactly that cycle.
- Input is accepted every cycle; there is no backpressure. Throughput is one comparison per clock.
- If in_valid=0 at an edge:
  - out_valid goes to 0.
  - y, max_o and min_o hold their last values; they are not cleared.
- After reset, exactly one bit of y is set once the first valid result has been registered.
- Unsigned mode: plain magnitude comparison; for WIDTH=4, values range 0..15.
- Signed mode: the MSB is the sign bit; for WIDTH=4, values range -8..7. Example: 4'b1000 (-8) < 4'b0111 (7).
- Equality is independent of mode (bitwise match).
- Comparison is purely combinational on the sampled inputs and then registered. There are no intermediate pipeline stages.
- Any in_valid pulse during or immediately before a reset assertion is discarded.
- Operand bits beyond WIDTH do not exist; the driving logic is responsible for truncation.

Test Plan:
- Reset with rst_n=0 mid-cycle, with no clock edge -> y=000, out_valid=0, max_o=min_o=0 immediately.
- Unsigned case 1: a=4'h2, b=4'hC, signed_mode=0, in_valid=1 -> next cycle y=001, max_o=C, min_o=2, out_valid=1.
- Unsigned case 2: a=4'h1, b=4'h1 -> y=010, max_o=min_o=1.
- Unsigned case 3: a=4'h1, b=4'h8 -> y=001, max_o=8, min_o=1.
- Signed: a=4'h1, b=4'h8, signed_mode=1 -> y=100 (1 > -8), max_o=1, min_o=8.
- Hold and reset-mid-stream: in_valid=0 for 3 cycles after a result -> out_valid=0 while y and max_o/min_o hold. Then assert rst_n=0 during a back-to-back valid stream -> all outputs clear at once. After release, the first valid input yields a correct result 1 cycle later.
